// File: rtl/shift_decoder_if.sv
// rtl/shift_decoder_if.sv - request/result handshake bundle for the shift decoder
interface shift_decoder_if #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout_obs;
  logic             res_valid;
  logic             res_ready;
  logic             found;
  logic [AMTW-1:0]  shiftamt;
  logic [2:0]       shifttype;

  modport master (
    output req_valid, datain, dataout_obs, res_ready,
    input  req_ready, res_valid, found, shiftamt, shifttype
  );

  modport slave (
    input  req_valid, datain, dataout_obs, res_ready,
    output req_ready, res_valid, found, shiftamt, shifttype
  );
endinterface

// File: rtl/shift_decoder.sv
// rtl/shift_decoder.sv - recovers shift amount/type from an original and shifted word
// One candidate amount per clock, all five shift types checked in priority order.
module shift_decoder #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_decoder_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2:0]      LP_SLL  = 3'b000;
  localparam logic [2:0]      LP_SRL  = 3'b001;
  localparam logic [2:0]      LP_SRA  = 3'b010;
  localparam logic [2:0]      LP_ROL  = 3'b011;
  localparam logic [2:0]      LP_ROR  = 3'b100;
  localparam logic [AMTW:0]   LP_W    = (AMTW+1)'(WIDTH);
  localparam logic [AMTW-1:0] LP_LAST = AMTW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_obs;
  logic [AMTW-1:0]  r_amt;
  logic             r_req_ready;
  logic             r_res_valid;
  logic             r_found;
  logic [AMTW-1:0]  r_shiftamt;
  logic [2:0]       r_shifttype;

  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [AMTW:0]    w_comp;
  logic             w_hit;
  logic [2:0]       w_type;

  // Complement amount is WIDTH at k=0, which shifts out everything and leaves the identity.
  assign w_comp = LP_W - {1'b0, r_amt};
  assign w_sll  = r_din << r_amt;
  assign w_srl  = r_din >> r_amt;
  assign w_sra  = $unsigned($signed(r_din) >>> r_amt);
  assign w_rol  = (r_din << r_amt) | (r_din >> w_comp);
  assign w_ror  = (r_din >> r_amt) | (r_din << w_comp);

  always_comb begin
    w_hit  = 1'b1;
    w_type = LP_SLL;
    if (w_sll == r_obs)      w_type = LP_SLL;
    else if (w_srl == r_obs) w_type = LP_SRL;
    else if (w_sra == r_obs) w_type = LP_SRA;
    else if (w_rol == r_obs) w_type = LP_ROL;
    else if (w_ror == r_obs) w_type = LP_ROR;
    else                     w_hit  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_din       <= '0;
      r_obs       <= '0;
      r_amt       <= '0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_found     <= 1'b0;
      r_shiftamt  <= '0;
      r_shifttype <= LP_SLL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_din       <= bus.datain;
            r_obs       <= bus.dataout_obs;
            r_amt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_found     <= 1'b1;
            r_shiftamt  <= r_amt;
            r_shifttype <= w_type;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_amt == LP_LAST) begin
            r_found     <= 1'b0;
            r_shiftamt  <= '0;
            r_shifttype <= LP_SLL;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_amt <= r_amt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.found     = r_found;
  assign bus.shiftamt  = r_shiftamt;
  assign bus.shifttype = r_shifttype;
endmodule

// File: tb/tb_shift_decoder.sv
// tb/tb_shift_decoder.sv - directed self-checking bench for shift_decoder
module tb_shift_decoder;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  shift_decoder_if #(.WIDTH(8), .AMTW(3)) bus ();

  shift_decoder #(.WIDTH(8), .AMTW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure edges to res_valid, optionally stall the result, then retire it.
  task automatic run(input string tag, input logic [7:0] din, input logic [7:0] obs,
                     input logic ef, input logic [2:0] ea, input logic [2:0] et,
                     input int elat, input int hold, input bit disturb);
    int n;
    check({tag, ".req_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.datain      = din;
    bus.dataout_obs = obs;
    bus.req_valid   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, ".req_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      if (disturb) begin
        bus.req_valid   = n[0];
        bus.datain      = ~bus.datain;
        bus.dataout_obs = bus.dataout_obs ^ 8'h5a;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    check({tag, ".latency"},   n,                       elat);
    check({tag, ".found"},     {31'd0, bus.found},     {31'd0, ef});
    check({tag, ".shiftamt"},  {29'd0, bus.shiftamt},  {29'd0, ea});
    check({tag, ".shifttype"}, {29'd0, bus.shifttype}, {29'd0, et});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'd0, bus.res_valid}, 32'd1);
      check({tag, ".hold_rdy"},   {31'd0, bus.req_ready}, 32'd0);
      check({tag, ".hold_amt"},   {29'd0, bus.shiftamt},  {29'd0, ea});
      check({tag, ".hold_type"},  {29'd0, bus.shifttype}, {29'd0, et});
      check({tag, ".hold_found"}, {31'd0, bus.found},     {31'd0, ef});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, ".retire_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, ".retire_rdy"},   {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.res_ready   = 1'b0;
    bus.datain      = '0;
    bus.dataout_obs = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst.res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst.found",     {31'd0, bus.found},     32'd0);
    check("rst.shiftamt",  {29'd0, bus.shiftamt},  32'd0);
    check("rst.shifttype", {29'd0, bus.shifttype}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("sll3",   8'b11100101, 8'b00101000, 1'b1, 3'd3, 3'b000, 4, 0, 1'b0);
    run("sra3",   8'b11100101, 8'b11111100, 1'b1, 3'd3, 3'b010, 4, 0, 1'b0);
    run("ror3",   8'b11100101, 8'b10111100, 1'b1, 3'd3, 3'b100, 4, 0, 1'b0);
    run("rol3",   8'b11100101, 8'b00101111, 1'b1, 3'd3, 3'b011, 4, 0, 1'b0);
    run("prio",   8'b01100000, 8'b00011000, 1'b1, 3'd2, 3'b001, 3, 0, 1'b0);
    run("ident",  8'b10100101, 8'b10100101, 1'b1, 3'd0, 3'b000, 1, 0, 1'b0);
    run("nomatch",8'b11100101, 8'b01010101, 1'b0, 3'd0, 3'b000, 8, 0, 1'b0);
    run("bp",     8'b11100101, 8'b10111100, 1'b1, 3'd3, 3'b100, 4, 5, 1'b1);
    run("after_bp",8'b11100101, 8'b00101111, 1'b1, 3'd3, 3'b011, 4, 0, 1'b0);

    // Abort two edges into the search; outputs must return to reset values without a clock.
    bus.datain      = 8'b11100101;
    bus.dataout_obs = 8'b00101000;
    bus.req_valid   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort.res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("abort.found",     {31'd0, bus.found},     32'd0);
    check("abort.shiftamt",  {29'd0, bus.shiftamt},  32'd0);
    check("abort.shifttype", {29'd0, bus.shifttype}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("post_rst", 8'b11100101, 8'b00101000, 1'b1, 3'd3, 3'b000, 4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_decoder.md
Name: shift_decoder

Overview:
- Inverse-direction companion to the datapath barrel shifter. Given an original word and a shifted word, it determines which shift amount and shift type produced the shifted word.
- Sequential search engine: tests one candidate shift amount per clock, checking every shift type for that amount in a fixed priority order.
- Sits on the checker/verification side of the shifter datapath. Used for self-check and for recovering the operation from logged data.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 8, data word width in bits (power of two, ≥4).
- AMTW, 3, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- datain  input  WIDTH  original (unshifted) word
- dataout_obs  input  WIDTH  observed shifted word
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- found  output  1  a match was found
- shiftamt  output  AMTW  recovered amount
- shifttype  output  3  recovered type

Behaviour:
- Shift-type encoding:
  - 000 = logical left
  - 001 = logical right
  - 010 = arithmetic right
  - 011 = rotate left
  - 100 = rotate right
  - Codes 101–111 are never reported.
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - req_ready=1, res_valid=0, found=0, shiftamt=0, shifttype=000.
  - Captured operands are cleared.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, capture datain and dataout_obs, set the amount counter to 0, and go to SEARCH.
  - Call this accept edge "edge 0".
- SEARCH:
  - req_ready=0. req_valid is ignored; no request is queued.
  - In the cycle after edge k, evaluate amount k against all five types combinationally.
  - Priority on a tie is 000 > 001 > 010 > 011 > 100; the lowest amount always wins because amounts are searched in ascending order.
- Match at amount k:
  - At edge k+1, register found=1, shiftamt=k, shifttype=the winning code.
  - Go to DONE.
- No match after amount WIDTH-1:
  - At edge WIDTH, register found=0, shiftamt=0, shifttype=000.
  - Go to DONE.
  - Latency is therefore k+1 cycles on a match and WIDTH cycles worst case.
- DONE:
  - res_valid=1; all outputs are held stable.
  - On an edge with res_ready=1, drop res_valid and return to IDLE; req_ready rises the next cycle.
  - A request cannot be accepted on the same edge as result retirement.
- Shift definitions for amount k:
  - Logical shifts zero-fill.
  - Arithmetic right replicates the captured datain MSB.
  - Rotates wrap modulo WIDTH.
  - Amount 0 makes every type equal the identity, so it always reports 000.
- Ambiguity is resolved by the rules above, never flagged:
  - ROL k equals ROR (WIDTH-k); the smaller k wins.
  - SRA equals SRL when the MSB is 0; SRL wins.
- Inputs are sampled only at the accept edge; later changes to datain or dataout_obs have no effect.
- Reset asserted mid-SEARCH or in DONE aborts immediately; the pending result is lost.
- Outputs are registered; there is no combinational path from the inputs to res_valid or the result fields.

Test Plan:
1. datain=11100101, dataout_obs=00101000 → res_valid at edge 4; found=1, shiftamt=3, shifttype=000.
2. datain=11100101, dataout_obs=11111100 → shiftamt=3, shifttype=010. Also dataout_obs=10111100 → shiftamt=3, shifttype=100 (not ROL 5). Also dataout_obs=00101111 → shiftamt=3, shifttype=011.
3. Priority case: datain=01100000, dataout_obs=00011000 → shiftamt=2, shifttype=001. Identity case: datain=dataout_obs=10100101 → res_valid at edge 1; shiftamt=0, shifttype=000.
4. No match: datain=11100101, dataout_obs=01010101 → res_valid at edge 8; found=0, shiftamt=0, shifttype=000.
5. Backpressure:
   - Hold res_ready=0 for 5 cycles in DONE → outputs stable and req_ready=0 throughout.
   - Toggle req_valid and datain during SEARCH → no effect on the result.
   - Release res_ready → back to IDLE, and the next request is accepted.
6. Reset: assert rst_n=0 two cycles into SEARCH → immediate IDLE with all outputs at reset values. The next request, case 1 again, completes correctly.
